// File: rtl/instr_encoder_pkg.sv
// Shared types and constants for the instruction encoder / memory loader.
package instr_encoder_pkg;

   localparam int OP_W     = 6;
   localparam int REG_W    = 5;
   localparam int SHAMT_W  = 5;
   localparam int FUNCT_W  = 6;
   localparam int IMM_W    = 16;
   localparam int TARGET_W = 26;
   localparam int WORD_W   = 32;

   // An unknown opcode is replaced by an all-zero word, which MIPS executes as a NOP.
   localparam logic [WORD_W-1:0] NOP_WORD = '0;

   typedef enum logic [OP_W-1:0] {
      OP_RTYPE = 6'b000000,
      OP_J     = 6'b000010,
      OP_BEQ   = 6'b000100,
      OP_LW    = 6'b100011,
      OP_SW    = 6'b101011
   } opcode_type;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_DRAIN,
      ST_DONE
   } enc_state_t;

endpackage

// File: rtl/instr_encoder_if.sv
// Valid/ready stream carrying one instruction description per transfer.
// The opcode travels as raw bits so that illegal encodings can reach the
// encoder and be flagged there.
interface instr_encoder_if;
   import instr_encoder_pkg::*;

   logic                in_valid;
   logic                in_ready;
   logic [OP_W-1:0]     in_op;
   logic [REG_W-1:0]    in_rs;
   logic [REG_W-1:0]    in_rt;
   logic [REG_W-1:0]    in_rd;
   logic [FUNCT_W-1:0]  in_funct;
   logic [IMM_W-1:0]    in_imm;
   logic [TARGET_W-1:0] in_target;
   logic                in_last;

   modport master (
      output in_valid, in_op, in_rs, in_rt, in_rd, in_funct, in_imm, in_target, in_last,
      input  in_ready
   );

   modport slave (
      input  in_valid, in_op, in_rs, in_rt, in_rd, in_funct, in_imm, in_target, in_last,
      output in_ready
   );

endinterface

// File: rtl/instr_pack.sv
// Combinational packer: turns an opcode plus its fields into a 32-bit MIPS word.
module instr_pack
   import instr_encoder_pkg::*;
(
   input  logic [OP_W-1:0]     i_op,
   input  logic [REG_W-1:0]    i_rs,
   input  logic [REG_W-1:0]    i_rt,
   input  logic [REG_W-1:0]    i_rd,
   input  logic [FUNCT_W-1:0]  i_funct,
   input  logic [IMM_W-1:0]    i_imm,
   input  logic [TARGET_W-1:0] i_target,
   output logic [WORD_W-1:0]   o_word,
   output logic                o_unknown
);

   // Select the field layout by instruction format; anything unrecognised becomes a flagged NOP.
   always_comb begin
      o_word    = NOP_WORD;
      o_unknown = 1'b0;
      case (i_op)
         OP_RTYPE:            o_word = {OP_RTYPE, i_rs, i_rt, i_rd, {SHAMT_W{1'b0}}, i_funct};
         OP_LW, OP_SW, OP_BEQ: o_word = {i_op, i_rs, i_rt, i_imm};
         OP_J:                o_word = {i_op, i_target};
         default:             o_unknown = 1'b1;
      endcase
   end

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder and instruction-memory loader: accepts instruction
// descriptions on a stream, packs them and writes them to consecutive
// instruction-memory words, reporting completion and error status.
module instr_encoder
   import instr_encoder_pkg::*;
#(
   parameter int          ADDR_W    = 8,
   parameter int unsigned BASE_ADDR = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   instr_encoder_if.slave    in_if,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [WORD_W-1:0] mem_wdata,
   output logic [ADDR_W:0]   count,
   output logic              done,
   output logic              err_op,
   output logic              err_full
);

   localparam logic [ADDR_W-1:0] BASE_PTR  = ADDR_W'(BASE_ADDR);
   localparam logic [ADDR_W:0]   DEPTH_CNT = {1'b1, {ADDR_W{1'b0}}};

   enc_state_t          r_state;
   enc_state_t          w_nextState;
   logic [ADDR_W-1:0]   r_wrPtr;
   logic [ADDR_W:0]     r_count;
   logic                r_memWe;
   logic [ADDR_W-1:0]   r_memAddr;
   logic [WORD_W-1:0]   r_memWdata;
   logic                r_errOp;
   logic                r_errFull;

   logic [WORD_W-1:0]   w_word;
   logic                w_unknown;
   logic                w_accept;
   logic                w_armStart;
   logic [ADDR_W:0]     w_countInc;
   logic                w_fillsMem;

   instr_pack u_pack (
      .i_op      (in_if.in_op),
      .i_rs      (in_if.in_rs),
      .i_rt      (in_if.in_rt),
      .i_rd      (in_if.in_rd),
      .i_funct   (in_if.in_funct),
      .i_imm     (in_if.in_imm),
      .i_target  (in_if.in_target),
      .o_word    (w_word),
      .o_unknown (w_unknown)
   );

   assign in_if.in_ready = (r_state == ST_LOAD);
   assign w_accept       = in_if.in_valid && in_if.in_ready;
   assign w_armStart     = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
   assign w_countInc     = r_count + 1'b1;
   assign w_fillsMem     = (w_countInc == DEPTH_CNT);

   // Hold the session state; reset always returns to IDLE.
   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_nextState;
   end

   // Sequence a session: arm on start, stream until last or full, drain the final write, then report done.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         ST_IDLE, ST_DONE: if (start) w_nextState = ST_LOAD;
         ST_LOAD:          if (w_accept && (in_if.in_last || w_fillsMem)) w_nextState = ST_DRAIN;
         ST_DRAIN:         w_nextState = ST_DONE;
         default:          w_nextState = ST_IDLE;
      endcase
   end

   // Register each accepted word with its address so the memory write lands exactly one cycle after the handshake.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wrPtr    <= '0;
         r_count    <= '0;
         r_memWe    <= 1'b0;
         r_memAddr  <= '0;
         r_memWdata <= '0;
         r_errOp    <= 1'b0;
         r_errFull  <= 1'b0;
      end else begin
         r_memWe <= w_accept;
         if (w_armStart) begin
            r_wrPtr   <= BASE_PTR;
            r_count   <= '0;
            r_errOp   <= 1'b0;
            r_errFull <= 1'b0;
         end else if (w_accept) begin
            r_memAddr  <= r_wrPtr;
            r_memWdata <= w_word;
            r_wrPtr    <= r_wrPtr + 1'b1;
            r_count    <= w_countInc;
            if (w_unknown) r_errOp <= 1'b1;
            if (w_fillsMem && !in_if.in_last) r_errFull <= 1'b1;
         end
      end
   end

   assign mem_we    = r_memWe;
   assign mem_addr  = r_memAddr;
   assign mem_wdata = r_memWdata;
   assign count     = r_count;
   assign done      = (r_state == ST_DONE);
   assign err_op    = r_errOp;
   assign err_full  = r_errFull;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: one instance with the default 256-word
// memory and one with a 4-word memory starting at address 2 (wrap and full cases).
module tb_instr_encoder;
   import instr_encoder_pkg::*;

   typedef struct packed {
      logic [7:0]  addr;
      logic [31:0] data;
   } wr_t;

   logic clk = 1'b0;
   logic rst;
   logic startA, startB;

   logic        tbValid, tbLast;
   logic [5:0]  tbOp, tbFunct;
   logic [4:0]  tbRs, tbRt, tbRd;
   logic [15:0] tbImm;
   logic [25:0] tbTarget;

   logic        memWeA, doneA, errOpA, errFullA;
   logic [7:0]  memAddrA;
   logic [31:0] memWdataA;
   logic [8:0]  countA;

   logic        memWeB, doneB, errOpB, errFullB;
   logic [1:0]  memAddrB;
   logic [31:0] memWdataB;
   logic [2:0]  countB;

   wr_t expA[$];
   wr_t expB[$];
   int  total = 0;
   int  bad = 0;
   int  stallCycles = 0;

   instr_encoder_if ifA ();
   instr_encoder_if ifB ();

   // Both instances see the same stream; only the armed one raises in_ready.
   assign ifA.in_valid = tbValid;  assign ifB.in_valid = tbValid;
   assign ifA.in_op = tbOp;        assign ifB.in_op = tbOp;
   assign ifA.in_rs = tbRs;        assign ifB.in_rs = tbRs;
   assign ifA.in_rt = tbRt;        assign ifB.in_rt = tbRt;
   assign ifA.in_rd = tbRd;        assign ifB.in_rd = tbRd;
   assign ifA.in_funct = tbFunct;  assign ifB.in_funct = tbFunct;
   assign ifA.in_imm = tbImm;      assign ifB.in_imm = tbImm;
   assign ifA.in_target = tbTarget; assign ifB.in_target = tbTarget;
   assign ifA.in_last = tbLast;    assign ifB.in_last = tbLast;

   instr_encoder #(.ADDR_W(8), .BASE_ADDR(0)) dutA (
      .clk(clk), .rst(rst), .start(startA), .in_if(ifA),
      .mem_we(memWeA), .mem_addr(memAddrA), .mem_wdata(memWdataA),
      .count(countA), .done(doneA), .err_op(errOpA), .err_full(errFullA)
   );

   instr_encoder #(.ADDR_W(2), .BASE_ADDR(2)) dutB (
      .clk(clk), .rst(rst), .start(startB), .in_if(ifB),
      .mem_we(memWeB), .mem_addr(memAddrB), .mem_wdata(memWdataB),
      .count(countB), .done(doneB), .err_op(errOpB), .err_full(errFullB)
   );

   // Free-running clock, 10 ns period.
   always #5 clk = ~clk;

   // Monitor for instance A: every write must match the oldest expected write.
   always @(negedge clk) begin
      wr_t e;
      if (memWeA) begin
         total++;
         if (expA.size() == 0) begin
            bad++;
            $display("[TB] FAIL writeA unexpected: got addr=%0h data=%08h, expected none", memAddrA, memWdataA);
         end else begin
            e = expA.pop_front();
            if (e.addr !== memAddrA || e.data !== memWdataA) begin
               bad++;
               $display("[TB] FAIL writeA: got addr=%0h data=%08h, expected addr=%0h data=%08h",
                        memAddrA, memWdataA, e.addr, e.data);
            end
         end
      end
   end

   // Monitor for instance B.
   always @(negedge clk) begin
      wr_t e;
      if (memWeB) begin
         total++;
         if (expB.size() == 0) begin
            bad++;
            $display("[TB] FAIL writeB unexpected: got addr=%0h data=%08h, expected none", memAddrB, memWdataB);
         end else begin
            e = expB.pop_front();
            if (e.addr !== {6'b0, memAddrB} || e.data !== memWdataB) begin
               bad++;
               $display("[TB] FAIL writeB: got addr=%0h data=%08h, expected addr=%0h data=%08h",
                        memAddrB, memWdataB, e.addr, e.data);
            end
         end
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   // Present one description (entered just after a negedge), queue its expected write, return after the accepting edge.
   task automatic applyStimulus(input bit sel, input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                input logic [4:0] rd, input logic [5:0] funct, input logic [15:0] imm,
                                input logic [25:0] target, input bit last,
                                input logic [7:0] eAddr, input logic [31:0] eData);
      bit rdyNow;
      int waited = 0;
      tbValid = 1'b1; tbOp = op; tbRs = rs; tbRt = rt; tbRd = rd;
      tbFunct = funct; tbImm = imm; tbTarget = target; tbLast = last;
      if (sel) expB.push_back({eAddr, eData});
      else     expA.push_back({eAddr, eData});
      forever begin
         rdyNow = sel ? ifB.in_ready : ifA.in_ready;
         @(negedge clk);
         if (rdyNow) break;
         waited++;
         stallCycles++;
         if (waited > 20) begin
            total++; bad++;
            $display("[TB] FAIL handshake timeout: got no accept in %0d cycles, expected accept", waited);
            break;
         end
      end
   endtask

   task automatic pulseStart(input bit sel);
      if (sel) startB = 1'b1; else startA = 1'b1;
      @(negedge clk);
      startA = 1'b0; startB = 1'b0;
   endtask

   task automatic endStream();
      tbValid = 1'b0;
      tbLast  = 1'b0;
   endtask

   initial begin
      rst = 1'b1; startA = 1'b0; startB = 1'b0;
      tbValid = 1'b0; tbLast = 1'b0; tbOp = '0; tbRs = '0; tbRt = '0; tbRd = '0;
      tbFunct = '0; tbImm = '0; tbTarget = '0;
      repeat (2) @(negedge clk);

      checkOutput("rstReady", ifA.in_ready, 0);
      checkOutput("rstWe", memWeA, 0);
      checkOutput("rstAddr", memAddrA, 0);
      checkOutput("rstData", memWdataA, 0);
      checkOutput("rstCount", countA, 0);
      checkOutput("rstFlags", {doneA, errOpA, errFullA}, 0);
      rst = 1'b0;
      @(negedge clk);

      // Single R-type with last.
      pulseStart(0);
      checkOutput("startReady", ifA.in_ready, 1);
      applyStimulus(0, OP_RTYPE, 5'd1, 5'd2, 5'd3, 6'h20, 16'h0, 26'h0, 1, 8'd0, 32'h0022_1820);
      endStream();
      checkOutput("lastReadyDrop", ifA.in_ready, 0);
      checkOutput("rtypeCount", countA, 1);
      checkOutput("doneEarly", doneA, 0);
      @(negedge clk);
      checkOutput("rtypeDone", doneA, 1);
      checkOutput("rtypeErrs", {errOpA, errFullA}, 0);

      // Back-to-back I-type and J-type burst.
      pulseStart(0);
      checkOutput("restartDone", doneA, 0);
      stallCycles = 0;
      applyStimulus(0, OP_LW,  5'd0, 5'd8, 5'd0, 6'h0, 16'h0004, 26'h0, 0, 8'd0, 32'h8C08_0004);
      applyStimulus(0, OP_SW,  5'd0, 5'd8, 5'd0, 6'h0, 16'h0008, 26'h0, 0, 8'd1, 32'hAC08_0008);
      applyStimulus(0, OP_BEQ, 5'd8, 5'd0, 5'd0, 6'h0, 16'hFFFF, 26'h0, 0, 8'd2, 32'h1100_FFFF);
      applyStimulus(0, OP_J,   5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h10,  1, 8'd3, 32'h0800_0010);
      endStream();
      checkOutput("burstStalls", stallCycles, 0);
      checkOutput("burstCount", countA, 4);
      @(negedge clk);
      checkOutput("burstDone", doneA, 1);

      // Illegal opcode mid-stream.
      pulseStart(0);
      applyStimulus(0, OP_LW,  5'd0, 5'd8, 5'd0, 6'h0, 16'h0004, 26'h0, 0, 8'd0, 32'h8C08_0004);
      checkOutput("errOpBefore", errOpA, 0);
      applyStimulus(0, 6'h3F,  5'd1, 5'd2, 5'd3, 6'h20, 16'h1234, 26'h0, 0, 8'd1, 32'h0000_0000);
      checkOutput("errOpSet", errOpA, 1);
      applyStimulus(0, OP_J,   5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h10,  1, 8'd2, 32'h0800_0010);
      endStream();
      checkOutput("illegalCount", countA, 3);
      @(negedge clk);
      checkOutput("illegalFlags", {doneA, errOpA, errFullA}, 3'b110);

      // Reset the cycle after a handshake drops the pending word.
      pulseStart(0);
      checkOutput("startClearsErrOp", errOpA, 0);
      applyStimulus(0, OP_SW, 5'd0, 5'd8, 5'd0, 6'h0, 16'h0008, 26'h0, 0, 8'd0, 32'hAC08_0008);
      tbOp = OP_LW; tbImm = 16'h0004;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      endStream();
      checkOutput("midRstWe", memWeA, 0);
      checkOutput("midRstReady", ifA.in_ready, 0);
      checkOutput("midRstOuts", {memAddrA, memWdataA[23:0]}, 0);
      checkOutput("midRstCount", countA, 0);
      pulseStart(0);
      checkOutput("rearmCount", countA, 0);
      applyStimulus(0, OP_J, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h3FF_FFFF, 1, 8'd0, 32'h0BFF_FFFF);
      endStream();
      checkOutput("rearmCount1", countA, 1);

      // Small memory: fill without last.
      pulseStart(1);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1, OP_J, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'(i + 1), 0,
                       8'((2 + i) % 4), 32'h0800_0000 | 32'(i + 1));
         if (i == 2) checkOutput("fullEarly", errFullB, 0);
      end
      endStream();
      checkOutput("fullReadyDrop", ifB.in_ready, 0);
      checkOutput("fullCount", countB, 4);
      checkOutput("fullErr", errFullB, 1);
      @(negedge clk);
      checkOutput("fullDone", doneB, 1);

      // Small memory: fill with last on the final word.
      pulseStart(1);
      for (int i = 0; i < 4; i++)
         applyStimulus(1, OP_BEQ, 5'd1, 5'd2, 5'd0, 6'h0, 16'(i), 26'h0, (i == 3),
                       8'((2 + i) % 4), 32'h1022_0000 | 32'(i));
      endStream();
      @(negedge clk);
      checkOutput("lastFullFlags", {doneB, errFullB}, 2'b10);

      // Small memory: wrap from base 2 with three words.
      pulseStart(1);
      applyStimulus(1, OP_LW, 5'd3, 5'd4, 5'd0, 6'h0, 16'h0010, 26'h0, 0, 8'd2, 32'h8C64_0010);
      applyStimulus(1, OP_SW, 5'd3, 5'd4, 5'd0, 6'h0, 16'h0014, 26'h0, 0, 8'd3, 32'hAC64_0014);
      applyStimulus(1, OP_RTYPE, 5'd4, 5'd5, 5'd6, 6'h22, 16'h0, 26'h0, 1, 8'd0, 32'h0085_3022);
      endStream();
      checkOutput("wrapCount", countB, 3);
      @(negedge clk);
      checkOutput("wrapFlags", {doneB, errOpB, errFullB}, 3'b100);

      repeat (3) @(negedge clk);
      checkOutput("pendingA", expA.size(), 0);
      checkOutput("pendingB", expB.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
